// File: rtl/bus_key_art_responder_if.sv
// Load/store bus between the core (initiator) and the key/art responder (target).
interface bus_key_art_responder_if;
  logic [63:0] bus_address;
  logic [63:0] bus_write_data;
  logic        bus_write_enable;
  logic        bus_read_enable;
  logic [63:0] bus_read_data;

  modport master (
    output bus_address, bus_write_data, bus_write_enable, bus_read_enable,
    input  bus_read_data
  );

  modport slave (
    input  bus_address, bus_write_data, bus_write_enable, bus_read_enable,
    output bus_read_data
  );
endinterface

// File: rtl/bus_key_art_responder.sv
// Bus target: key receive FIFO with interrupt, art transmit FIFO, status register.
// Define KEY_ECHO_EN to echo every popped key byte into the art FIFO.
`ifndef Key_base
`define Key_base 64'h0000_0000_F000_0000
`endif
`ifndef Art_base
`define Art_base 64'h0000_0000_F000_0100
`endif

module bus_key_art_responder #(
  parameter logic [63:0] KEY_ADDR  = `Key_base,
  parameter logic [63:0] ART_ADDR  = `Art_base,
  parameter logic [63:0] STAT_ADDR = `Key_base + 64'd8,
  parameter int unsigned KEY_DEPTH = 8,
  parameter int unsigned ART_DEPTH = 8,
  parameter logic [3:0]  IRQ_VEC   = 4'd1
) (
  input  logic                           clk,
  input  logic                           reset,
  bus_key_art_responder_if.slave         bus,
  input  logic [7:0]                     key_data,
  input  logic                           key_valid,
  output logic [7:0]                     art_data,
  output logic                           art_valid,
  input  logic                           art_ready,
  output logic [3:0]                     interrupt_vector,
  input  logic                           interrupt_ack
);

  localparam int unsigned KAW = $clog2(KEY_DEPTH);
  localparam int unsigned KCW = KAW + 1;
  localparam int unsigned AAW = $clog2(ART_DEPTH);
  localparam int unsigned ACW = AAW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_KEY_RD,
    S_STAT_RD,
    S_ART_WR
  } acc_state_e;

  acc_state_e r_state;
  acc_state_e w_state_nxt;

  logic [7:0]     r_key_mem [KEY_DEPTH];
  logic [KAW-1:0] r_key_wp;
  logic [KAW-1:0] r_key_rp;
  logic [KCW-1:0] r_key_cnt;
  logic           r_key_ovf;

  logic [7:0]     r_art_mem [ART_DEPTH];
  logic [AAW-1:0] r_art_wp;
  logic [AAW-1:0] r_art_rp;
  logic [ACW-1:0] r_art_cnt;
  logic           r_art_ovf;

  logic           r_irq_armed;

  logic           w_key_hit;
  logic           w_stat_hit;
  logic           w_art_hit;
  logic           w_key_pop_req;
  logic           w_ovf_clr;
  logic           w_art_bus_push;
  logic           w_key_full;
  logic           w_key_empty;
  logic           w_key_pop;
  logic           w_key_push;
  logic           w_key_drop;
  logic [7:0]     w_key_head;
  logic           w_art_full;
  logic           w_art_pop;
  logic           w_art_push_req;
  logic [7:0]     w_art_push_byte;
  logic           w_art_push;
  logic           w_art_drop;
  logic           w_echo_push;
  logic [7:0]     w_echo_byte;
  logic [63:0]    w_rd_data;
  logic           w_unused;

  assign w_key_hit  = (bus.bus_address == KEY_ADDR);
  assign w_stat_hit = (bus.bus_address == STAT_ADDR);
  assign w_art_hit  = (bus.bus_address == ART_ADDR);
  assign w_unused   = ^bus.bus_write_data[63:8];

  // Access tracker: each bus access produces its single effect at start or end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = S_IDLE;
    w_key_pop_req  = 1'b0;
    w_ovf_clr      = 1'b0;
    w_art_bus_push = 1'b0;
    if (bus.bus_read_enable && w_key_hit) begin
      w_state_nxt = S_KEY_RD;
    end else if (bus.bus_read_enable && w_stat_hit) begin
      w_state_nxt = S_STAT_RD;
    end else if (bus.bus_write_enable && w_art_hit) begin
      w_state_nxt = S_ART_WR;
    end
    w_key_pop_req  = (r_state == S_KEY_RD)  && (w_state_nxt != S_KEY_RD);
    w_ovf_clr      = (r_state == S_STAT_RD) && (w_state_nxt != S_STAT_RD);
    w_art_bus_push = (w_state_nxt == S_ART_WR) && (r_state != S_ART_WR);
  end

  // Key FIFO control: a pop frees a slot for a same-edge push even when full.
  assign w_key_empty = (r_key_cnt == '0);
  assign w_key_full  = (r_key_cnt == KCW'(KEY_DEPTH));
  assign w_key_head  = r_key_mem[r_key_rp];
  assign w_key_pop   = w_key_pop_req && !w_key_empty;
  assign w_key_push  = key_valid && (!w_key_full || w_key_pop);
  assign w_key_drop  = key_valid && w_key_full && !w_key_pop;

  always_ff @(posedge clk) begin
    if (w_key_push) begin
      r_key_mem[r_key_wp] <= key_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_key_wp  <= '0;
      r_key_rp  <= '0;
      r_key_cnt <= '0;
    end else begin
      if (w_key_push) begin
        r_key_wp <= r_key_wp + KAW'(1);
      end
      if (w_key_pop) begin
        r_key_rp <= r_key_rp + KAW'(1);
      end
      if (w_key_push && !w_key_pop) begin
        r_key_cnt <= r_key_cnt + KCW'(1);
      end else if (w_key_pop && !w_key_push) begin
        r_key_cnt <= r_key_cnt - KCW'(1);
      end
    end
  end

`ifdef KEY_ECHO_EN
  logic       r_echo_pend;
  logic [7:0] r_echo_byte;

  // A newer pop overwrites a pending echo; the older byte goes out on the same edge if it can.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_echo_pend <= 1'b0;
      r_echo_byte <= '0;
    end else if (w_key_pop) begin
      r_echo_pend <= 1'b1;
      r_echo_byte <= w_key_head;
    end else if (w_echo_push) begin
      r_echo_pend <= 1'b0;
    end
  end

  assign w_echo_push = r_echo_pend && !w_art_bus_push;
  assign w_echo_byte = r_echo_byte;
`else
  assign w_echo_push = 1'b0;
  assign w_echo_byte = '0;
`endif

  // Art FIFO: one push source per edge, bus store has priority over the echo.
  assign w_art_full      = (r_art_cnt == ACW'(ART_DEPTH));
  assign w_art_pop       = art_valid && art_ready;
  assign w_art_push_req  = w_art_bus_push || w_echo_push;
  assign w_art_push_byte = w_art_bus_push ? bus.bus_write_data[7:0] : w_echo_byte;
  assign w_art_push      = w_art_push_req && (!w_art_full || w_art_pop);
  assign w_art_drop      = w_art_push_req && w_art_full && !w_art_pop;

  always_ff @(posedge clk) begin
    if (w_art_push) begin
      r_art_mem[r_art_wp] <= w_art_push_byte;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_art_wp  <= '0;
      r_art_rp  <= '0;
      r_art_cnt <= '0;
    end else begin
      if (w_art_push) begin
        r_art_wp <= r_art_wp + AAW'(1);
      end
      if (w_art_pop) begin
        r_art_rp <= r_art_rp + AAW'(1);
      end
      if (w_art_push && !w_art_pop) begin
        r_art_cnt <= r_art_cnt + ACW'(1);
      end else if (w_art_pop && !w_art_push) begin
        r_art_cnt <= r_art_cnt - ACW'(1);
      end
    end
  end

  // Sticky overflow flags: a new drop beats a status-read clear on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_key_ovf <= 1'b0;
      r_art_ovf <= 1'b0;
    end else begin
      if (w_key_drop) begin
        r_key_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_key_ovf <= 1'b0;
      end
      if (w_art_drop) begin
        r_art_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_art_ovf <= 1'b0;
      end
    end
  end

  // Pop re-arms the interrupt and wins over a coincident acknowledge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_irq_armed <= 1'b1;
    end else if (w_key_pop) begin
      r_irq_armed <= 1'b1;
    end else if (interrupt_ack) begin
      r_irq_armed <= 1'b0;
    end
  end

  always_comb begin
    w_rd_data = '0;
    if (bus.bus_read_enable) begin
      if (w_key_hit && !w_key_empty) begin
        w_rd_data = {56'b0, w_key_head};
      end else if (w_stat_hit) begin
        w_rd_data = {32'b0, 8'(r_art_cnt), 8'(r_key_cnt), 14'b0, r_art_ovf, r_key_ovf};
      end
    end
  end

  assign bus.bus_read_data = w_rd_data;
  assign art_valid         = (r_art_cnt != '0);
  assign art_data          = r_art_mem[r_art_rp];
  assign interrupt_vector  = (!w_key_empty && r_irq_armed) ? IRQ_VEC : 4'd0;

endmodule

// File: tb/tb_bus_key_art_responder.sv
// Self-checking bench: directed vector table, hand sequences and a queue-based random model.
module tb_bus_key_art_responder;
  localparam logic [63:0] KA = 64'h0000_0000_F000_0000;
  localparam logic [63:0] AA = 64'h0000_0000_F000_0100;
  localparam logic [63:0] SA = KA + 64'd8;
  localparam int unsigned KD = 8;
  localparam int unsigned AD = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] key_data;
  logic       key_valid;
  logic [7:0] art_data;
  logic       art_valid;
  logic       art_ready;
  logic [3:0] interrupt_vector;
  logic       interrupt_ack;

  bus_key_art_responder_if bif();

  bus_key_art_responder #(
    .KEY_ADDR(KA), .ART_ADDR(AA), .STAT_ADDR(SA),
    .KEY_DEPTH(KD), .ART_DEPTH(AD), .IRQ_VEC(4'd1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bif),
    .key_data(key_data), .key_valid(key_valid),
    .art_data(art_data), .art_valid(art_valid), .art_ready(art_ready),
    .interrupt_vector(interrupt_vector), .interrupt_ack(interrupt_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          sel;
    bit          re;
    bit          we;
    logic [63:0] wd;
    bit          kv;
    logic [7:0]  kd;
    bit          ardy;
    bit          ack;
    logic [63:0] exp_rd;
    logic [3:0]  exp_irq;
    bit          chk_art;
    bit          exp_av;
    logic [7:0]  exp_ad;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(int sel, bit re, bit we, logic [63:0] wd, bit kv, logic [7:0] kd,
                             bit ardy, bit ack, logic [63:0] rd, logic [3:0] irq,
                             bit ca, bit av, logic [7:0] ad);
    vec_t r;
    r.sel = sel; r.re = re; r.we = we; r.wd = wd; r.kv = kv; r.kd = kd;
    r.ardy = ardy; r.ack = ack; r.exp_rd = rd; r.exp_irq = irq;
    r.chk_art = ca; r.exp_av = av; r.exp_ad = ad;
    return r;
  endfunction

  function automatic logic [63:0] sel_addr(int s);
    case (s)
      1:       return KA;
      2:       return SA;
      3:       return AA;
      default: return 64'h0000_0000_0000_1230;
    endcase
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(int sel, bit re, bit we, logic [63:0] wd, bit kv, logic [7:0] kd,
                       bit ardy, bit ack);
    bif.bus_address      = sel_addr(sel);
    bif.bus_read_enable  = re;
    bif.bus_write_enable = we;
    bif.bus_write_data   = wd;
    key_valid            = kv;
    key_data             = kd;
    art_ready            = ardy;
    interrupt_ack        = ack;
  endtask

  task automatic idle(bit ardy);
    drive(0, 1'b0, 1'b0, 64'd0, 1'b0, 8'd0, ardy, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle(1'b0);
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic run_table(string tag);
    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].sel, vt[i].re, vt[i].we, vt[i].wd, vt[i].kv, vt[i].kd, vt[i].ardy, vt[i].ack);
      #2;
      chk($sformatf("%s[%0d] rdata", tag, i), bif.bus_read_data, vt[i].exp_rd);
      chk($sformatf("%s[%0d] irq", tag, i), 64'(interrupt_vector), 64'(vt[i].exp_irq));
      if (vt[i].chk_art) begin
        chk($sformatf("%s[%0d] art_valid", tag, i), 64'(art_valid), 64'(vt[i].exp_av));
        if (vt[i].exp_av)
          chk($sformatf("%s[%0d] art_data", tag, i), 64'(art_data), 64'(vt[i].exp_ad));
      end
      tick();
    end
  endtask

  // Reference model state: plain queues and flags following the behavioural rules.
  logic [7:0] kq[$];
  logic [7:0] aq[$];
  bit         m_kovf, m_aovf, m_armed, m_krd, m_srd, m_awr, m_epend;
  logic [7:0] m_eb;

  task automatic model_reset();
    kq.delete(); aq.delete();
    m_kovf = 0; m_aovf = 0; m_armed = 1; m_krd = 0; m_srd = 0; m_awr = 0;
    m_epend = 0; m_eb = 8'd0;
  endtask

  task automatic model_check(int cyc);
    logic [63:0] exp_rd;
    exp_rd = 64'd0;
    if (bif.bus_read_enable && bif.bus_address == KA && kq.size() > 0)
      exp_rd = 64'(kq[0]);
    else if (bif.bus_read_enable && bif.bus_address == SA)
      exp_rd = (64'(aq.size()) << 24) | (64'(kq.size()) << 16) | (64'(m_aovf) << 1) | 64'(m_kovf);
    chk($sformatf("rand[%0d] rdata", cyc), bif.bus_read_data, exp_rd);
    chk($sformatf("rand[%0d] irq", cyc), 64'(interrupt_vector),
        (kq.size() > 0 && m_armed) ? 64'd1 : 64'd0);
    chk($sformatf("rand[%0d] art_valid", cyc), 64'(art_valid), 64'(aq.size() > 0));
    if (aq.size() > 0)
      chk($sformatf("rand[%0d] art_data", cyc), 64'(art_data), 64'(aq[0]));
  endtask

  task automatic model_edge();
    bit hit_k, hit_s, hit_a, pop, clr, apush, epush;
    logic [7:0] popped;
    hit_k  = bif.bus_read_enable && bif.bus_address == KA;
    hit_s  = bif.bus_read_enable && bif.bus_address == SA;
    hit_a  = bif.bus_write_enable && bif.bus_address == AA;
    pop    = m_krd && !hit_k && kq.size() > 0;
    popped = pop ? kq[0] : 8'd0;
    clr    = m_srd && !hit_s;
    apush  = hit_a && !m_awr;
    epush  = 0;
`ifdef KEY_ECHO_EN
    epush  = m_epend && !apush;
`endif
    if (clr) begin
      m_kovf = 0;
      m_aovf = 0;
    end
    if (pop) void'(kq.pop_front());
    if (key_valid) begin
      if (kq.size() < KD) kq.push_back(key_data);
      else m_kovf = 1;
    end
    if (aq.size() > 0 && art_ready) void'(aq.pop_front());
    if (apush || epush) begin
      if (aq.size() < AD) aq.push_back(apush ? bif.bus_write_data[7:0] : m_eb);
      else m_aovf = 1;
    end
    if (pop) begin
      m_eb = popped;
      m_epend = 1;
    end else if (epush) begin
      m_epend = 0;
    end
    if (pop) m_armed = 1;
    else if (interrupt_ack) m_armed = 0;
    m_krd = hit_k;
    m_srd = hit_s;
    m_awr = hit_a;
  endtask

  initial begin
    int  sel;
    bit  re, we, in_acc;
    logic [7:0] exp_keys[8];

    reset = 1'b0;
    do_reset();

    // Key read, interrupt acknowledge and re-raise.
    vt.delete();
    vt.push_back(v(0,0,0,0,0,8'h00,1,0, 64'h0,  4'd0, 1,0,8'h00));
    vt.push_back(v(0,0,0,0,1,8'h41,1,0, 64'h0,  4'd0, 0,0,8'h00));
    vt.push_back(v(1,1,0,0,0,8'h00,1,0, 64'h41, 4'd1, 0,0,8'h00));
    vt.push_back(v(1,1,0,0,0,8'h00,1,0, 64'h41, 4'd1, 0,0,8'h00));
    vt.push_back(v(1,0,0,0,0,8'h00,1,0, 64'h0,  4'd1, 0,0,8'h00));
    vt.push_back(v(2,1,0,0,0,8'h00,1,0, 64'h0,  4'd0, 0,0,8'h00));
    vt.push_back(v(0,0,0,0,1,8'h61,1,0, 64'h0,  4'd0, 0,0,8'h00));
    vt.push_back(v(0,0,0,0,1,8'h62,1,0, 64'h0,  4'd1, 0,0,8'h00));
    vt.push_back(v(0,0,0,0,0,8'h00,1,1, 64'h0,  4'd1, 0,0,8'h00));
    vt.push_back(v(0,0,0,0,0,8'h00,1,0, 64'h0,  4'd0, 0,0,8'h00));
    vt.push_back(v(1,1,0,0,0,8'h00,1,0, 64'h61, 4'd0, 0,0,8'h00));
    vt.push_back(v(0,0,0,0,0,8'h00,1,0, 64'h0,  4'd0, 0,0,8'h00));
    vt.push_back(v(0,0,0,0,0,8'h00,1,0, 64'h0,  4'd1, 0,0,8'h00));
    vt.push_back(v(1,1,0,0,0,8'h00,1,0, 64'h62, 4'd1, 0,0,8'h00));
    vt.push_back(v(0,0,0,0,0,8'h00,1,0, 64'h0,  4'd1, 0,0,8'h00));
    vt.push_back(v(0,0,0,0,0,8'h00,1,0, 64'h0,  4'd0, 0,0,8'h00));
    run_table("keyvec");

    // Art store held two cycles, one drain.
    do_reset();
    vt.delete();
    vt.push_back(v(3,0,1,64'h123,0,8'h00,0,0, 64'h0,         4'd0, 1,0,8'h00));
    vt.push_back(v(3,0,1,64'h123,0,8'h00,0,0, 64'h0,         4'd0, 1,1,8'h23));
    vt.push_back(v(0,0,0,64'h0,  0,8'h00,0,0, 64'h0,         4'd0, 1,1,8'h23));
    vt.push_back(v(2,1,0,64'h0,  0,8'h00,0,0, 64'h0100_0000, 4'd0, 1,1,8'h23));
    vt.push_back(v(0,0,0,64'h0,  0,8'h00,1,0, 64'h0,         4'd0, 1,1,8'h23));
    vt.push_back(v(0,0,0,64'h0,  0,8'h00,1,0, 64'h0,         4'd0, 1,0,8'h00));
    run_table("artvec");

    // Key overflow and sticky flag clear on status read end.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(0, 1'b0, 1'b0, 64'd0, 1'b1, 8'(i), 1'b1, 1'b0);
      tick();
    end
    drive(2, 1'b1, 1'b0, 64'd0, 1'b0, 8'd0, 1'b1, 1'b0);
    #2 chk("ovf status first", bif.bus_read_data, 64'h0008_0001);
    tick();
    idle(1'b1);
    tick();
    drive(2, 1'b1, 1'b0, 64'd0, 1'b0, 8'd0, 1'b1, 1'b0);
    #2 chk("ovf status second", bif.bus_read_data, 64'h0008_0000);
    tick();
    idle(1'b1);
    tick();

    // Full FIFO: pop and push on the same edge.
    drive(1, 1'b1, 1'b0, 64'd0, 1'b0, 8'd0, 1'b1, 1'b0);
    #2 chk("full head", bif.bus_read_data, 64'h0);
    tick();
    drive(1, 1'b0, 1'b0, 64'd0, 1'b1, 8'hAA, 1'b1, 1'b0);
    tick();
    idle(1'b1);
    tick();
    tick();
    drive(2, 1'b1, 1'b0, 64'd0, 1'b0, 8'd0, 1'b1, 1'b0);
    #2 chk("full push+pop status", bif.bus_read_data, 64'h0008_0000);
    tick();
    idle(1'b1);
    tick();
    for (int i = 0; i < 7; i++) exp_keys[i] = 8'(i + 1);
    exp_keys[7] = 8'hAA;
    for (int i = 0; i < 8; i++) begin
      drive(1, 1'b1, 1'b0, 64'd0, 1'b0, 8'd0, 1'b1, 1'b0);
      #2 chk($sformatf("drain key %0d", i), bif.bus_read_data, 64'(exp_keys[i]));
      tick();
      idle(1'b1);
      tick();
    end

    // Reset asserted in the middle of a key read.
    drive(0, 1'b0, 1'b0, 64'd0, 1'b1, 8'h33, 1'b0, 1'b0);
    tick();
    drive(1, 1'b1, 1'b0, 64'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    #2 chk("pre-reset head", bif.bus_read_data, 64'h33);
    reset = 1'b0;
    #1 chk("reset rdata", bif.bus_read_data, 64'h0);
    chk("reset irq", 64'(interrupt_vector), 64'h0);
    chk("reset art_valid", 64'(art_valid), 64'h0);
    tick();
    idle(1'b0);
    tick();
    reset = 1'b1;
    tick();
    drive(2, 1'b1, 1'b0, 64'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    #2 chk("post-reset status", bif.bus_read_data, 64'h0);
    tick();

`ifdef KEY_ECHO_EN
    // Echo of a popped key queued behind a bus store on the following edge.
    do_reset();
    drive(0, 1'b0, 1'b0, 64'd0, 1'b1, 8'h7A, 1'b0, 1'b0);
    tick();
    drive(1, 1'b1, 1'b0, 64'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    tick();
    idle(1'b0);
    tick();
    drive(3, 1'b0, 1'b1, 64'h55, 1'b0, 8'd0, 1'b0, 1'b0);
    #2 chk("echo none yet", 64'(art_valid), 64'h0);
    tick();
    idle(1'b0);
    tick();
    #2 chk("echo order first", 64'(art_data), 64'h55);
    art_ready = 1'b1;
    tick();
    #2 chk("echo order second", 64'(art_data), 64'h7A);
    tick();
    #2 chk("echo drained", 64'(art_valid), 64'h0);
    tick();
`endif

    // Randomized traffic against the queue model.
    do_reset();
    model_reset();
    sel = 0; re = 0; we = 0; in_acc = 0;
    for (int c = 0; c < 3000; c++) begin
      if (in_acc && $urandom_range(0, 2) != 0) begin
        // hold the current access
      end else if (in_acc) begin
        in_acc = 0; re = 0; we = 0;
        sel = $urandom_range(0, 3);
      end else if ($urandom_range(0, 2) == 0) begin
        in_acc = 1;
        sel = $urandom_range(0, 3);
        if ($urandom_range(0, 1) == 0) begin re = 1; we = 0; end
        else begin re = 0; we = 1; end
      end else begin
        sel = $urandom_range(0, 3);
      end
      drive(sel, re, we, {$urandom, $urandom}, $urandom_range(0, 9) < 3, 8'($urandom),
            $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
      #2 model_check(c);
      model_edge();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
